// File: rtl/imuldiv_muldiv_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imuldiv_muldiv_defs (package)
// Description : Shared definitions for the iterative mul/div subsystem:
//               function codes, the request record, divider response field
//               bounds and small decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package imuldiv_muldiv_defs;

    localparam int FN_W = 3;

    localparam logic [FN_W-1:0] FN_MUL  = 3'd0;
    localparam logic [FN_W-1:0] FN_DIV  = 3'd1;
    localparam logic [FN_W-1:0] FN_DIVU = 3'd2;
    localparam logic [FN_W-1:0] FN_REM  = 3'd3;
    localparam logic [FN_W-1:0] FN_REMU = 3'd4;

    // Divider response layout: {rem[63:32], quot[31:0]}
    localparam int DIVRESP_REM_HI  = 63;
    localparam int DIVRESP_REM_LO  = 32;
    localparam int DIVRESP_QUOT_HI = 31;
    localparam int DIVRESP_QUOT_LO = 0;

    typedef struct packed {
        logic [FN_W-1:0] fn;
        logic [31:0]     a;
        logic [31:0]     b;
    } muldiv_req_t;

    // Anything that is not a divide-type code (including the reserved
    // codes 5-7) is handled by the multiplier.
    function automatic logic fn_is_div(input logic [FN_W-1:0] fn);
        return (fn == FN_DIV) || (fn == FN_DIVU) || (fn == FN_REM) || (fn == FN_REMU);
    endfunction

    function automatic logic fn_is_mul(input logic [FN_W-1:0] fn);
        return (fn == FN_MUL) || !fn_is_div(fn);
    endfunction

    function automatic logic fn_is_rem(input logic [FN_W-1:0] fn);
        return (fn == FN_REM) || (fn == FN_REMU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/imuldiv_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : imuldiv_tag_fifo
// Description : Small circular FIFO recording the function code of every
//               issued operation so responses can be returned in order.
//   clk, reset      : clock, synchronous active-high reset
//   push, push_data : enqueue (ignored while full, even with a same-cycle pop)
//   pop             : dequeue (ignored while empty)
//   full, empty     : status (full is registered)
//   head            : oldest entry
// Revision    : 1.0 - initial release
// ============================================================================
module imuldiv_tag_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             do_push;
    logic             do_pop;

    // No full-bypass: a push is refused whenever the registered full is set.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
            full  <= (count_next == CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/imuldiv_muldiv_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : imuldiv_muldiv_dispatch
// Description : Front-end dispatcher for the iterative mul/div units. Buffers
//               one request, routes it to the multiplier or divider, records
//               its function code in an in-order tag FIFO and returns
//               responses to the pipeline in request order. Remainder results
//               are swapped so bits [31:0] always hold the requested value.
//   muldivreq_*  : request from pipeline (fn, a, b / val, rdy)
//   mulreq_*     : request to multiplier        divreq_* : request to divider
//   mulresp_*    : product from multiplier      divresp_*: {rem, quot}
//   muldivresp_* : result to pipeline
// Revision    : 1.0 - initial release
// ============================================================================
module imuldiv_muldiv_dispatch
    import imuldiv_muldiv_defs::*;
#(
    parameter int TAG_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [FN_W-1:0] muldivreq_msg_fn,
    input  logic [31:0]     muldivreq_msg_a,
    input  logic [31:0]     muldivreq_msg_b,
    input  logic            muldivreq_val,
    output logic            muldivreq_rdy,
    output logic [31:0]     mulreq_msg_a,
    output logic [31:0]     mulreq_msg_b,
    output logic            mulreq_val,
    input  logic            mulreq_rdy,
    output logic [FN_W-1:0] divreq_msg_fn,
    output logic [31:0]     divreq_msg_a,
    output logic [31:0]     divreq_msg_b,
    output logic            divreq_val,
    input  logic            divreq_rdy,
    input  logic [63:0]     mulresp_msg_result,
    input  logic            mulresp_val,
    output logic            mulresp_rdy,
    input  logic [63:0]     divresp_msg_result,
    input  logic            divresp_val,
    output logic            divresp_rdy,
    output logic [63:0]     muldivresp_msg_result,
    output logic            muldivresp_val,
    input  logic            muldivresp_rdy
);

    muldiv_req_t     req_buf;
    logic            buf_full;
    logic            is_mul;
    logic            dispatch_fire;
    logic            accept;
    logic            tag_full;
    logic            tag_empty;
    logic [FN_W-1:0] tag_head;
    logic            head_is_mul;
    logic            resp_fire;
    logic [63:0]     div_result_norm;

    // ---------------- request buffer ----------------
    assign is_mul        = fn_is_mul(req_buf.fn);
    assign mulreq_val    = buf_full && is_mul && !tag_full;
    assign divreq_val    = buf_full && !is_mul && !tag_full;
    assign dispatch_fire = (mulreq_val && mulreq_rdy) || (divreq_val && divreq_rdy);
    assign muldivreq_rdy = !buf_full || dispatch_fire;
    assign accept        = muldivreq_val && muldivreq_rdy;

    assign mulreq_msg_a  = req_buf.a;
    assign mulreq_msg_b  = req_buf.b;
    assign divreq_msg_fn = req_buf.fn;
    assign divreq_msg_a  = req_buf.a;
    assign divreq_msg_b  = req_buf.b;

    // A refill in the dispatch cycle keeps the buffer occupied.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_full <= 1'b0;
        end else if (accept) begin
            buf_full <= 1'b1;
        end else if (dispatch_fire) begin
            buf_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            req_buf <= '{fn: muldivreq_msg_fn, a: muldivreq_msg_a, b: muldivreq_msg_b};
        end
    end

    // ---------------- in-order tag record ----------------
    imuldiv_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .WIDTH (FN_W)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (dispatch_fire),
        .push_data (req_buf.fn),
        .pop       (resp_fire),
        .full      (tag_full),
        .empty     (tag_empty),
        .head      (tag_head)
    );

    // ---------------- response selection ----------------
    // Only the unit owning the oldest operation may hand over a result; an
    // early answer from the other unit is held off by its rdy staying low.
    assign head_is_mul    = fn_is_mul(tag_head);
    assign muldivresp_val = !tag_empty && (head_is_mul ? mulresp_val : divresp_val);
    assign mulresp_rdy    = !tag_empty && head_is_mul && muldivresp_rdy;
    assign divresp_rdy    = !tag_empty && !head_is_mul && muldivresp_rdy;
    assign resp_fire      = muldivresp_val && muldivresp_rdy;

    always_comb begin
        div_result_norm = divresp_msg_result;
        if (fn_is_rem(tag_head)) begin
            div_result_norm = {divresp_msg_result[DIVRESP_QUOT_HI:DIVRESP_QUOT_LO],
                               divresp_msg_result[DIVRESP_REM_HI:DIVRESP_REM_LO]};
        end
    end

    assign muldivresp_msg_result = head_is_mul ? mulresp_msg_result : div_result_norm;

endmodule

`default_nettype wire

// File: tb/tb_imuldiv_muldiv_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_imuldiv_muldiv_dispatch
// Description : Self-checking bench for imuldiv_muldiv_dispatch with simple
//               behavioural multiply/divide unit models and a pipeline
//               consumer, each controlled by knobs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imuldiv_muldiv_dispatch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  muldivreq_msg_fn = 3'd0;
    logic [31:0] muldivreq_msg_a = '0;
    logic [31:0] muldivreq_msg_b = '0;
    logic        muldivreq_val = 1'b0;
    logic        muldivreq_rdy;
    logic [31:0] mulreq_msg_a, mulreq_msg_b;
    logic        mulreq_val;
    logic        mulreq_rdy = 1'b0;
    logic [2:0]  divreq_msg_fn;
    logic [31:0] divreq_msg_a, divreq_msg_b;
    logic        divreq_val;
    logic        divreq_rdy = 1'b0;
    logic [63:0] mulresp_msg_result = '0;
    logic        mulresp_val = 1'b0;
    logic        mulresp_rdy;
    logic [63:0] divresp_msg_result = '0;
    logic        divresp_val = 1'b0;
    logic        divresp_rdy;
    logic [63:0] muldivresp_msg_result;
    logic        muldivresp_val;
    logic        muldivresp_rdy = 1'b0;

    always #5 clk = ~clk;

    imuldiv_muldiv_dispatch #(.TAG_DEPTH(2)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .muldivreq_msg_fn      (muldivreq_msg_fn),
        .muldivreq_msg_a       (muldivreq_msg_a),
        .muldivreq_msg_b       (muldivreq_msg_b),
        .muldivreq_val         (muldivreq_val),
        .muldivreq_rdy         (muldivreq_rdy),
        .mulreq_msg_a          (mulreq_msg_a),
        .mulreq_msg_b          (mulreq_msg_b),
        .mulreq_val            (mulreq_val),
        .mulreq_rdy            (mulreq_rdy),
        .divreq_msg_fn         (divreq_msg_fn),
        .divreq_msg_a          (divreq_msg_a),
        .divreq_msg_b          (divreq_msg_b),
        .divreq_val            (divreq_val),
        .divreq_rdy            (divreq_rdy),
        .mulresp_msg_result    (mulresp_msg_result),
        .mulresp_val           (mulresp_val),
        .mulresp_rdy           (mulresp_rdy),
        .divresp_msg_result    (divresp_msg_result),
        .divresp_val           (divresp_val),
        .divresp_rdy           (divresp_rdy),
        .muldivresp_msg_result (muldivresp_msg_result),
        .muldivresp_val        (muldivresp_val),
        .muldivresp_rdy        (muldivresp_rdy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Knobs: mode 0 = low, 1 = high, 2 = random each cycle
    int mul_mode = 1, div_mode = 1, resp_mode = 1;
    int mul_lat_min = 1, mul_lat_max = 1, div_lat_min = 1, div_lat_max = 1;
    bit force_val = 1'b0;

    typedef struct { logic [63:0] r; int t; } pend_t;
    pend_t       mq[$];
    pend_t       dq[$];
    logic [63:0] got[$];
    logic [63:0] exp_q[$];
    int          cyc = 0;

    // ---------------- arithmetic reference ----------------
    function automatic logic [63:0] unit_mul(input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    // Raw divider answer {rem, quot}
    function automatic logic [63:0] unit_div(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
        int sa, sb, q, r;
        if (fn == 3'd1 || fn == 3'd3) begin
            sa = $signed(a); sb = $signed(b);
            q = sa / sb; r = sa % sb;
            return {32'(r), 32'(q)};
        end
        return {a % b, a / b};
    endfunction

    // What the pipeline must receive for a request
    function automatic logic [63:0] ref_result(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] d;
        d = unit_div(fn, a, b);
        case (fn)
            3'd1, 3'd2: return d;
            3'd3, 3'd4: return {d[31:0], d[63:32]};
            default:    return unit_mul(a, b);
        endcase
    endfunction

    function automatic logic mode_bit(input int m);
        if (m == 0) return 1'b0;
        if (m == 1) return 1'b1;
        return 1'($urandom_range(0, 1));
    endfunction

    // ---------------- unit models and pipeline consumer ----------------
    initial begin : units
        logic mpush, mpop, dpush, dpop, rs;
        logic [63:0] mres, dres;
        mpush = 0; mpop = 0; dpush = 0; dpop = 0; rs = 1; mres = '0; dres = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rs) begin
                mq.delete(); dq.delete();
            end else begin
                if (mpop && mq.size() > 0) void'(mq.pop_front());
                if (dpop && dq.size() > 0) void'(dq.pop_front());
                if (mpush) mq.push_back('{mres, cyc - 1 + $urandom_range(mul_lat_min, mul_lat_max)});
                if (dpush) dq.push_back('{dres, cyc - 1 + $urandom_range(div_lat_min, div_lat_max)});
            end
            mulreq_rdy     = mode_bit(mul_mode);
            divreq_rdy     = mode_bit(div_mode);
            muldivresp_rdy = mode_bit(resp_mode);
            mulresp_val        = force_val || (mq.size() > 0 && mq[0].t <= cyc);
            mulresp_msg_result = (mq.size() > 0) ? mq[0].r : 64'h0;
            divresp_val        = force_val || (dq.size() > 0 && dq[0].t <= cyc);
            divresp_msg_result = (dq.size() > 0) ? dq[0].r : 64'h0;
            #1;
            rs    = reset;
            mpop  = !reset && mulresp_val && mulresp_rdy;
            dpop  = !reset && divresp_val && divresp_rdy;
            mpush = !reset && mulreq_val && mulreq_rdy;
            dpush = !reset && divreq_val && divreq_rdy;
            mres  = unit_mul(mulreq_msg_a, mulreq_msg_b);
            dres  = dpush ? unit_div(divreq_msg_fn, divreq_msg_a, divreq_msg_b) : 64'h0;
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            #1;
            if (!reset && muldivresp_val && muldivresp_rdy) got.push_back(muldivresp_msg_result);
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        muldivreq_val = 1'b1; muldivreq_msg_fn = fn; muldivreq_msg_a = a; muldivreq_msg_b = b;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (muldivreq_rdy) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            #1;
            exp_q.push_back(ref_result(fn, a, b));
        end
        muldivreq_val = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL issue_accept fn=%0d: muldivreq_rdy stayed 0, required 1 within 300 cycles", fn);
        end
    endtask

    task automatic wait_results(input int n);
        for (int i = 0; i < 1000 && got.size() < n; i++) begin
            @(negedge clk);
            #2;
        end
        n_cmp++;
        if (got.size() < n) begin
            n_bad++;
            $display("FAIL wait_results: got %0d results, required %0d", got.size(), n);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1;
        n_cmp++; if (muldivreq_rdy !== 1'b1) begin n_bad++; $display("FAIL reset_muldivreq_rdy: got %b required 1", muldivreq_rdy); end
        n_cmp++; if (mulreq_val !== 1'b0) begin n_bad++; $display("FAIL reset_mulreq_val: got %b required 0", mulreq_val); end
        n_cmp++; if (divreq_val !== 1'b0) begin n_bad++; $display("FAIL reset_divreq_val: got %b required 0", divreq_val); end
        n_cmp++; if (muldivresp_val !== 1'b0) begin n_bad++; $display("FAIL reset_muldivresp_val: got %b required 0", muldivresp_val); end
        // Unit valids forced high while nothing is outstanding
        force_val = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if (muldivresp_val !== 1'b0) begin n_bad++; $display("FAIL empty_resp_val: got %b required 0", muldivresp_val); end
        n_cmp++; if (mulresp_rdy !== 1'b0) begin n_bad++; $display("FAIL empty_mulresp_rdy: got %b required 0", mulresp_rdy); end
        n_cmp++; if (divresp_rdy !== 1'b0) begin n_bad++; $display("FAIL empty_divresp_rdy: got %b required 0", divresp_rdy); end
        @(posedge clk);
        force_val = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mul();
        logic [63:0] r;
        issue(3'd0, 32'd3, 32'hFFFF_FFFB);
        @(negedge clk); #1;
        n_cmp++; if (mulreq_val !== 1'b1) begin n_bad++; $display("FAIL mul_req_val: got %b required 1", mulreq_val); end
        n_cmp++; if (mulreq_msg_a !== 32'd3 || mulreq_msg_b !== 32'hFFFF_FFFB)
            begin n_bad++; $display("FAIL mul_req_ops: got %h/%h required 00000003/fffffffb", mulreq_msg_a, mulreq_msg_b); end
        wait_results(1);
        r = (got.size() > 0) ? got.pop_front() : 64'hx;
        void'(exp_q.pop_front());
        n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_FFF1) begin n_bad++; $display("FAIL mul_result: got %h required ffffffff_fffffff1", r); end
    endtask

    task automatic test_rem();
        logic [63:0] r;
        issue(3'd3, 32'd7, 32'd2);
        @(negedge clk); #1;
        n_cmp++; if (divreq_val !== 1'b1 || divreq_msg_fn !== 3'd3)
            begin n_bad++; $display("FAIL rem_req: got val=%b fn=%0d required val=1 fn=3", divreq_val, divreq_msg_fn); end
        wait_results(1);
        r = (got.size() > 0) ? got.pop_front() : 64'hx;
        void'(exp_q.pop_front());
        n_cmp++; if (r !== 64'h0000_0003_0000_0001) begin n_bad++; $display("FAIL rem_result: got %h required 00000003_00000001", r); end
    endtask

    task automatic test_ordering();
        bit early_div, leak;
        logic [63:0] r;
        early_div = 0; leak = 0;
        mul_lat_min = 8; mul_lat_max = 8;
        issue(3'd0, 32'd2, 32'd3);
        issue(3'd2, 32'd9, 32'd4);
        for (int i = 0; i < 60 && got.size() < 2; i++) begin
            @(negedge clk); #2;
            if (got.size() == 0 && divresp_val) early_div = 1;
            if (got.size() == 0 && divresp_rdy) leak = 1;
        end
        n_cmp++; if (early_div !== 1'b1) begin n_bad++; $display("FAIL order_div_early: got %b required 1", early_div); end
        n_cmp++; if (leak !== 1'b0) begin n_bad++; $display("FAIL order_divresp_rdy_held: got %b required 0", leak); end
        r = (got.size() > 0) ? got.pop_front() : 64'hx;
        n_cmp++; if (r !== 64'd6) begin n_bad++; $display("FAIL order_first: got %h required 6", r); end
        r = (got.size() > 0) ? got.pop_front() : 64'hx;
        n_cmp++; if (r !== 64'h0000_0001_0000_0002) begin n_bad++; $display("FAIL order_second: got %h required 00000001_00000002", r); end
        exp_q.delete();
        mul_lat_min = 1; mul_lat_max = 1;
    endtask

    task automatic test_capacity();
        bit bad_val, bad_rdy;
        logic [63:0] r, e;
        bad_val = 0; bad_rdy = 0;
        resp_mode = 0;
        for (int k = 0; k < 3; k++) issue(3'd0, 32'(k + 10), 32'(k + 2));
        muldivreq_val = 1'b1; muldivreq_msg_fn = 3'd0; muldivreq_msg_a = 32'd13; muldivreq_msg_b = 32'd5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #2;
            if (mulreq_val !== 1'b0) bad_val = 1;
            if (muldivreq_rdy !== 1'b0) bad_rdy = 1;
        end
        muldivreq_val = 1'b0;
        n_cmp++; if (bad_val) begin n_bad++; $display("FAIL cap_mulreq_val: got 1 required 0 while tags full"); end
        n_cmp++; if (bad_rdy) begin n_bad++; $display("FAIL cap_muldivreq_rdy: got 1 required 0 while buffer and tags full"); end
        n_cmp++; if (got.size() != 0) begin n_bad++; $display("FAIL cap_no_results: got %0d results required 0", got.size()); end
        @(posedge clk);
        resp_mode = 1;
        issue(3'd0, 32'd13, 32'd5);
        wait_results(4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            r = (got.size() > 0) ? got.pop_front() : 64'hx;
            n_cmp++; if (r !== e) begin n_bad++; $display("FAIL cap_drain: got %h required %h", r, e); end
        end
    endtask

    task automatic test_backpressure();
        bit bad;
        logic [63:0] r, e;
        bad = 0;
        resp_mode = 0;
        issue(3'd0, 32'h1234, 32'h10);
        e = exp_q[0];
        for (int i = 0; i < 20 && !mulresp_val; i++) begin @(negedge clk); #2; end
        n_cmp++; if (mulresp_val !== 1'b1) begin n_bad++; $display("FAIL bp_unit_val: got %b required 1", mulresp_val); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #2;
            if (mulresp_rdy !== 1'b0 || muldivresp_val !== 1'b1 || muldivresp_msg_result !== e) bad = 1;
        end
        n_cmp++; if (bad) begin n_bad++; $display("FAIL bp_hold: rdy/val/result changed, required rdy=0 val=1 result=%h", e); end
        n_cmp++; if (got.size() != 0) begin n_bad++; $display("FAIL bp_no_pop: got %0d results required 0", got.size()); end
        @(posedge clk);
        resp_mode = 1;
        wait_results(1);
        r = (got.size() > 0) ? got.pop_front() : 64'hx;
        void'(exp_q.pop_front());
        n_cmp++; if (r !== 64'h0000_0000_0001_2340) begin n_bad++; $display("FAIL bp_result: got %h required 00000000_00012340", r); end
    endtask

    task automatic test_reset_midop();
        logic [63:0] r;
        resp_mode = 0; mul_lat_min = 30; mul_lat_max = 30;
        for (int k = 0; k < 3; k++) issue(3'd0, 32'(k + 1), 32'd7);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        #1;
        exp_q.delete();
        n_cmp++; if (mulreq_val !== 1'b0 || divreq_val !== 1'b0 || muldivresp_val !== 1'b0)
            begin n_bad++; $display("FAIL midrst_vals: got mul=%b div=%b resp=%b required 0", mulreq_val, divreq_val, muldivresp_val); end
        n_cmp++; if (muldivreq_rdy !== 1'b1) begin n_bad++; $display("FAIL midrst_rdy: got %b required 1", muldivreq_rdy); end
        @(posedge clk);
        mul_lat_min = 1; mul_lat_max = 1; resp_mode = 1;
        issue(3'd0, 32'd4, 32'd5);
        wait_results(1);
        repeat (5) @(negedge clk);
        r = (got.size() > 0) ? got.pop_front() : 64'hx;
        void'(exp_q.pop_front());
        n_cmp++; if (r !== 64'd20) begin n_bad++; $display("FAIL midrst_result: got %h required 20", r); end
        n_cmp++; if (got.size() != 0) begin n_bad++; $display("FAIL midrst_stale: got %0d extra results required 0", got.size()); end
    endtask

    task automatic test_random();
        logic [2:0]  fn;
        logic [31:0] a, b;
        logic [63:0] r, e;
        mul_mode = 2; div_mode = 2; resp_mode = 2;
        mul_lat_min = 1; mul_lat_max = 4; div_lat_min = 1; div_lat_max = 4;
        for (int k = 0; k < 40; k++) begin
            fn = 3'($urandom_range(0, 7));
            a  = (k % 3 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            b  = (k % 4 == 0) ? 32'($urandom_range(1, 9)) : $urandom;
            if (b == 32'd0) b = 32'd1;
            if ((fn == 3'd1 || fn == 3'd3) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            issue(fn, a, b);
        end
        wait_results(exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            r = (got.size() > 0) ? got.pop_front() : 64'hx;
            n_cmp++; if (r !== e) begin n_bad++; $display("FAIL random_result: got %h required %h", r, e); end
        end
        mul_mode = 1; div_mode = 1; resp_mode = 1;
    endtask

    initial begin : main
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_mul();
        test_rem();
        test_ordering();
        test_capacity();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/imuldiv_muldiv_dispatch.md
Name: imuldiv_muldiv_dispatch

Overview:
Front-end dispatcher for the iterative mul/div subsystem. Accepts unified muldiv requests from the pipeline and routes each one to the iterative multiply unit or the iterative divide unit. Keeps an in-order record of every issued operation, so responses return to the pipeline in request order. Normalises the divider result so that bits [31:0] always hold the architecturally requested value.

Parameters:
TAG_DEPTH, 2, number of in-flight operations tracked (power of 2, at least 2)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
muldivreq_msg_fn  in  3  op: MUL=0, DIV=1, DIVU=2, REM=3, REMU=4
muldivreq_msg_a  in  32  operand A
muldivreq_msg_b  in  32  operand B
muldivreq_val  in  1  request valid
muldivreq_rdy  out  1  request ready
mulreq_msg_a  out  32  to multiplier
mulreq_msg_b  out  32  to multiplier
mulreq_val  out  1  multiplier request valid
mulreq_rdy  in  1  multiplier ready
divreq_msg_fn  out  3  fn passed to divider
divreq_msg_a  out  32  to divider
divreq_msg_b  out  32  to divider
divreq_val  out  1  divider request valid
divreq_rdy  in  1  divider ready
mulresp_msg_result  in  64  product
mulresp_val  in  1  product valid
mulresp_rdy  out  1  product accepted
divresp_msg_result  in  64  {rem[63:32], quot[31:0]}
divresp_val  in  1  divider result valid
divresp_rdy  out  1  divider result accepted
muldivresp_msg_result  out  64  result to pipeline
muldivresp_val  out  1  result valid
muldivresp_rdy  in  1  pipeline ready

Behaviour:
- Reset is synchronous, active-high, on clock clk.
- Reset state: request buffer empty, tag FIFO empty.
- Reset output values: muldivreq_rdy=1, every *_val=0, mulresp_rdy=0, divresp_rdy=0.
- Request buffer: one entry holding {fn, a, b}.
  - muldivreq_rdy = !buf_full || dispatch_fire.
  - A transfer occurs on val && rdy.
  - Minimum latency from accept to unit request is one cycle.
- Routing: fn=MUL goes to the multiplier; fn 1–4 go to the divider.
- Reserved fn 5–7 are routed as MUL and no error is raised.
- Dispatch conditions:
  - mulreq_val = buf_full && is_mul && !tag_full.
  - divreq_val = buf_full && !is_mul && !tag_full.
  - Operand and fn outputs are driven straight from the buffer. They stay stable while val is high and the unit's rdy is low.
- dispatch_fire = unit val && unit rdy. On dispatch_fire, push buffered fn into the tag FIFO and clear the buffer, unless it is refilled in the same cycle.
- Tag FIFO:
  - Depth TAG_DEPTH, width 3 bits (fn).
  - Circular read/write pointers plus a count.
  - tag_full is registered. A push is refused when full, even if a pop happens in the same cycle (no full-bypass).
  - Simultaneous push and pop when not full or empty: count is unchanged and both pointers advance.
- Response selection: the head fn selects the source unit.
  - Head MUL: muldivresp_val = !tag_empty && mulresp_val; mulresp_rdy = !tag_empty && muldivresp_rdy.
  - Head div-type: same rule using divresp_val and divresp_rdy.
  - The non-selected unit's resp_rdy is 0, so an out-of-order early response is held off.
- Response payload:
  - MUL, DIV, DIVU: pass through unchanged.
  - REM, REMU: swap halves to {quot, rem}.
- Pop the tag FIFO on muldivresp_val && muldivresp_rdy.
- Empty FIFO: muldivresp_val=0 and both resp_rdy=0, whatever the unit val inputs are.
- Reset mid-operation: buffer and FIFO clear on the next edge. The units share the same reset, so in-flight operations are discarded and no response is produced.

Decomposition:
- Shared package imuldiv_muldiv_defs holds:
  - FN_MUL, FN_DIV, FN_DIVU, FN_REM, FN_REMU localparams;
  - FN_W=3;
  - DIVRESP_REM_HI / DIVRESP_QUOT_LO field bounds.
- One sub-module: imuldiv_tag_fifo (parameterised depth/width, synchronous reset, ports push/pop/full/empty/head).
- Dispatch and response muxing stay in the top module.

Test Plan:
- MUL, a=3, b=0xFFFFFFFB:
  - mulreq_val=1 with a=3, b=0xFFFFFFFB one cycle after accept;
  - unit model returns 0xFFFFFFFF_FFFFFFF1, and muldivresp_msg_result equals 0xFFFFFFFF_FFFFFFF1.
- REM, a=7, b=2:
  - divreq_msg_fn=3;
  - div model returns 0x00000001_00000003, and muldivresp_msg_result equals 0x00000003_00000001.
- Ordering:
  - MUL(2,3) followed by DIVU(9,4); div model answers first;
  - divresp_rdy stays 0 until the result 6 is consumed;
  - then 0x00000001_00000002 is delivered.
- Capacity (TAG_DEPTH=2):
  - hold muldivresp_rdy=0, issue 4 MULs;
  - two dispatch, the third stays in the buffer with mulreq_val=0, and muldivreq_rdy=0 on the 4th;
  - raising rdy drains all 4 in order.
- Backpressure:
  - mulresp_val=1 with muldivresp_rdy=0 for 10 cycles;
  - mulresp_rdy=0 throughout, result stable, FIFO count unchanged.
- Reset mid-op:
  - assert reset with 1 buffered and 2 tagged operations;
  - next cycle all vals=0, muldivreq_rdy=1;
  - a new MUL(4,5) returns 20.
